// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, IF/ID payload and fetch constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // addi x0,x0,0 -- placed in IF/ID for bubbles and flushes
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  // Sequential fetch address; wraps modulo 2^32
  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding imem FSM, one-entry hold buffer, IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pc_enable,
  input  logic           IF_ID_enable,
  input  logic           IF_ID_flush,
  input  logic           redirect,
  input  logic [31:0]    redirect_pc,
  fetch_stage_if.master  imem,
  output logic [31:0]    pc_F,
  output logic [31:0]    instr_D,
  output logic [31:0]    pc_D,
  output logic           valid_D,
  output logic           fetch_bubble
);

  import pipeline_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc_f;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_hold_instr;
  logic [31:0]  r_hold_pc;
  logic         w_capture;
  if_id_t       r_if_id;
  logic         r_fetch_bubble;

  logic         w_stall;
  logic         w_avail;
  logic         w_deliver;
  logic [31:0]  w_dlv_instr;
  logic [31:0]  w_dlv_pc;

  assign w_stall   = !(pc_enable && IF_ID_enable);
  assign w_deliver = w_avail && !w_stall && !redirect;

  // A request goes out only from ISSUE, never while a redirect is changing the PC,
  // and is held low while the stage sits in reset.
  assign imem.imem_req  = (r_state == ISSUE) && !redirect && rst_n;
  assign imem.imem_addr = r_pc_f;

  assign pc_F         = r_pc_f;
  assign instr_D      = r_if_id.instr;
  assign pc_D         = r_if_id.pc;
  assign valid_D      = r_if_id.valid;
  assign fetch_bubble = r_fetch_bubble;

  // Select the instruction available this cycle: a fresh response or the hold buffer
  always_comb begin
    w_avail     = 1'b0;
    w_dlv_instr = imem.imem_rdata;
    w_dlv_pc    = r_pc_f;
    case (r_state)
      WAIT: begin
        w_avail = imem.imem_rvalid;
      end
      HOLD: begin
        w_avail     = 1'b1;
        w_dlv_instr = r_hold_instr;
        w_dlv_pc    = r_hold_pc;
      end
      default: begin
        w_avail = 1'b0;
      end
    endcase
  end

  // Fetch FSM next state and PC update; redirect always wins over stall
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc_f;
    w_capture   = 1'b0;
    case (r_state)
      ISSUE: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = ISSUE;
          end else if (!w_stall) begin
            w_pc_nxt    = pc_step(r_pc_f);
            w_state_nxt = ISSUE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (redirect) begin
          // Response still in flight: it must be absorbed before re-requesting
          w_pc_nxt    = redirect_pc;
          w_state_nxt = DROP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ISSUE;
        end else if (!w_stall) begin
          w_pc_nxt    = pc_step(r_pc_f);
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) begin
          w_state_nxt = ISSUE;
          if (redirect) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = r_pc_f;
          end
        end else if (redirect) begin
          w_pc_nxt = redirect_pc;
        end else begin
          w_state_nxt = DROP;
        end
      end
      default: begin
        w_state_nxt = ISSUE;
      end
    endcase
  end

  // FSM state, PC and hold-buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ISSUE;
      r_pc_f       <= RESET_PC;
      r_hold_instr <= 32'h0000_0000;
      r_hold_pc    <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc_f  <= w_pc_nxt;
      if (w_capture) begin
        r_hold_instr <= imem.imem_rdata;
        r_hold_pc    <= r_pc_f;
      end
    end
  end

  // IF/ID register: flush/redirect, then hold, then deliver, else latency bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id.instr  <= NOP_INSTR;
      r_if_id.pc     <= 32'h0000_0000;
      r_if_id.valid  <= 1'b0;
      r_fetch_bubble <= 1'b0;
    end else if (IF_ID_flush || redirect) begin
      r_if_id.instr  <= NOP_INSTR;
      r_if_id.valid  <= 1'b0;
      r_fetch_bubble <= 1'b0;
    end else if (!IF_ID_enable) begin
      r_fetch_bubble <= 1'b0;
    end else if (w_deliver) begin
      r_if_id.instr  <= w_dlv_instr;
      r_if_id.pc     <= w_dlv_pc;
      r_if_id.valid  <= 1'b1;
      r_fetch_bubble <= 1'b0;
    end else begin
      r_if_id.instr  <= NOP_INSTR;
      r_if_id.valid  <= 1'b0;
      r_fetch_bubble <= 1'b1;
    end
  end

endmodule
